// File: rtl/pe_reducer_sched_pkg.sv
// Shared types and sizing for the PE reducer sequencer: FSM states, lane record
// and the widths used by both the interface and the sequencer.
package pe_reducer_sched_pkg;

  localparam int LANES   = 3;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int NNZ_W   = 9;
  localparam int TMO_W   = 8;
  localparam int LADDR_W = 3 * ADDR_W;
  localparam int LCNT_W  = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [LADDR_W-1:0] addr;
    logic [DATA_W-1:0]  w;
    logic [DATA_W-1:0]  ia;
  } lane_t;

  // A zero lane contributes a zero product, so it is safe as padding.
  function automatic lane_t lane_zero();
    lane_t z;
    z.addr = {LADDR_W{1'b0}};
    z.w    = {DATA_W{1'b0}};
    z.ia   = {DATA_W{1'b0}};
    return z;
  endfunction

endpackage

// File: rtl/pe_reducer_sched_if.sv
// Tile command, entry stream and PE issue bundle between a tile source,
// the sequencer (slave side) and the PE reducer.
interface pe_reducer_sched_if;
  import pe_reducer_sched_pkg::*;

  logic                             start;
  logic [NNZ_W-1:0]                 nnz;
  logic                             ent_valid;
  logic                             ent_ready;
  logic [LADDR_W-1:0]               ent_addr;
  logic [DATA_W-1:0]                ent_w;
  logic [DATA_W-1:0]                ent_ia;
  logic                             pe_start;
  logic [LANES-1:0][LADDR_W-1:0]    pe_addr;
  logic [LANES-1:0][DATA_W-1:0]     pe_w;
  logic [LANES-1:0][DATA_W-1:0]     pe_ia;
  logic                             pe_finish;
  logic                             busy;
  logic                             done;
  logic [NNZ_W-1:0]                 groups;
  logic                             err;

  modport slave (
    input  start, nnz, ent_valid, ent_addr, ent_w, ent_ia, pe_finish,
    output ent_ready, pe_start, pe_addr, pe_w, pe_ia, busy, done, groups, err
  );

  modport master (
    output start, nnz, ent_valid, ent_addr, ent_w, ent_ia, pe_finish,
    input  ent_ready, pe_start, pe_addr, pe_w, pe_ia, busy, done, groups, err
  );

endinterface

// File: rtl/pe_reducer_sched.sv
// Sequencer in front of the PE reducer: packs a tile's nonzero entries LANES
// at a time, issues each group to the PE and waits for it to finish.
module pe_reducer_sched
  import pe_reducer_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pe_reducer_sched_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

  state_t             state_r;
  lane_t              lanes_r [LANES];
  logic [LCNT_W-1:0]  lane_cnt_r;
  logic [NNZ_W-1:0]   remaining_r;
  logic [TMO_W-1:0]   tmo_r;
  logic               pe_start_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic [NNZ_W-1:0]   groups_r;

  logic               ready_s;
  logic               accept_s;
  logic               last_s;
  lane_t              ent_s;

  assign ent_s = '{addr: bus.ent_addr, w: bus.ent_w, ia: bus.ent_ia};

  // Entry handshake and end-of-group detection from registered state only.
  always_comb begin
    ready_s = 1'b0;
    if ((state_r == ST_COLLECT) && (lane_cnt_r < LCNT_W'(LANES)) &&
        (remaining_r != {NNZ_W{1'b0}})) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = ready_s & bus.ent_valid;
    last_s   = (lane_cnt_r == LCNT_W'(LANES - 1)) || (remaining_r == NNZ_W'(1));
  end

  // Tile sequencing FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lane_cnt_r  <= {LCNT_W{1'b0}};
      remaining_r <= {NNZ_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      pe_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      groups_r    <= {NNZ_W{1'b0}};
      for (int i = 0; i < LANES; i++) lanes_r[i] <= lane_zero();
    end else begin
      pe_start_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            groups_r <= {NNZ_W{1'b0}};
            err_r    <= 1'b0;
            busy_r   <= 1'b1;
            if (bus.nnz != {NNZ_W{1'b0}}) begin
              remaining_r <= bus.nnz;
              lane_cnt_r  <= {LCNT_W{1'b0}};
              for (int i = 0; i < LANES; i++) lanes_r[i] <= lane_zero();
              state_r     <= ST_COLLECT;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end
        end
        ST_COLLECT: begin
          if (accept_s) begin
            lanes_r[lane_cnt_r] <= ent_s;
            lane_cnt_r          <= lane_cnt_r + LCNT_W'(1);
            remaining_r         <= remaining_r - NNZ_W'(1);
            if (last_s) begin
              pe_start_r <= 1'b1;
              state_r    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          groups_r <= groups_r + NNZ_W'(1);
          tmo_r    <= {TMO_W{1'b0}};
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A finish arriving on the timeout cycle still completes normally.
          if (bus.pe_finish) begin
            if (remaining_r == {NNZ_W{1'b0}}) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              lane_cnt_r <= {LCNT_W{1'b0}};
              for (int i = 0; i < LANES; i++) lanes_r[i] <= lane_zero();
              state_r    <= ST_COLLECT;
            end
          end else if (tmo_r == TMO_MAX) begin
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane_out
    assign bus.pe_addr[g] = lanes_r[g].addr;
    assign bus.pe_w[g]    = lanes_r[g].w;
    assign bus.pe_ia[g]   = lanes_r[g].ia;
  end

  assign bus.ent_ready = ready_s;
  assign bus.pe_start  = pe_start_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.groups    = groups_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_pe_reducer_sched.sv
// Self-checking bench for pe_reducer_sched: table of tiles with a lane-group
// scoreboard, plus hand sequences for WAIT-state start/reset and PE timeout.
module tb_pe_reducer_sched;
  import pe_reducer_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_reducer_sched_if bus();
  pe_reducer_sched dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [LANES-1:0][LADDR_W-1:0] addr;
    logic [LANES-1:0][DATA_W-1:0]  w;
    logic [LANES-1:0][DATA_W-1:0]  ia;
  } grp_t;

  typedef struct {
    int       nnz;
    bit [7:0] vpat;
    int       fin;
    int       exp_groups;
  } vec_t;

  grp_t exp_q[$];
  vec_t tbl[7];
  int   n_vec = 0;
  int   n_err = 0;
  int   pe_start_cnt = 0;
  bit   pe_auto = 1'b1;
  int   fin_dly = 4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lane_t gen(input int tag, input int k);
    lane_t e;
    e.addr = LADDR_W'(tag * 256 + k);
    e.w    = DATA_W'(15 + k + tag * 100);
    e.ia   = DATA_W'(3 - k + tag * 50);
    return e;
  endfunction

  task automatic push_exp(input int tag, input int nnz);
    for (int g = 0; g * LANES < nnz; g++) begin
      grp_t x;
      x.addr = '0;
      x.w    = '0;
      x.ia   = '0;
      for (int l = 0; l < LANES; l++) begin
        int k;
        lane_t e;
        k = g * LANES + l;
        if (k < nnz) begin
          e = gen(tag, k);
          x.addr[l] = e.addr;
          x.w[l]    = e.w;
          x.ia[l]   = e.ia;
        end
      end
      exp_q.push_back(x);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pe_start"}, 64'(bus.pe_start), 64'(0));
    check({tag, "_ent_ready"}, 64'(bus.ent_ready), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_groups"}, 64'(bus.groups), 64'(0));
    check({tag, "_err"}, 64'(bus.err), 64'(0));
    check({tag, "_lanes"}, 64'(bus.pe_addr) | 64'(bus.pe_w) | 64'(bus.pe_ia), 64'(0));
  endtask

  // Scoreboard: every issued group must match the next expected group.
  initial begin : monitor
    grp_t x;
    forever begin
      @(negedge clk);
      if (!rst && bus.pe_start) begin
        pe_start_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: pe_start seen, expected no issue");
        end else begin
          x = exp_q.pop_front();
          check("lane_addr", 64'(bus.pe_addr), 64'(x.addr));
          check("lane_w", 64'(bus.pe_w), 64'(x.w));
          check("lane_ia", 64'(bus.pe_ia), 64'(x.ia));
        end
      end
    end
  end

  // PE model: finish fin_dly cycles after each observed issue.
  initial begin : pe_model
    int d;
    bus.pe_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pe_start && pe_auto && !rst) begin
        d = fin_dly;
        repeat (d - 1) @(negedge clk);
        bus.pe_finish = 1'b1;
        @(negedge clk);
        bus.pe_finish = 1'b0;
      end
    end
  end

  task automatic run_tile(input int tag, input int nnz, input bit [7:0] vpat,
                          input int budget, input bit exp_done, input bit exp_err,
                          input int exp_groups, output int cyc_done, output int start_cyc);
    int    k;
    int    ps0;
    int    late_ready;
    bit    seen;
    lane_t e;
    k = 0; late_ready = 0; seen = 1'b0;
    cyc_done = -1; start_cyc = -1;
    push_exp(tag, nnz);
    ps0 = pe_start_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.nnz   = NNZ_W'(nnz);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (c == 0) begin
        check("busy_after_start", 64'(bus.busy), 64'(1));
        check("err_after_start", 64'(bus.err), 64'(0));
      end
      if (bus.pe_start && start_cyc < 0) start_cyc = c;
      if (bus.done) begin
        cyc_done = c;
        seen = 1'b1;
        break;
      end
      if (k >= nnz && bus.ent_ready) late_ready++;
      e = gen(tag, k);
      bus.ent_valid = vpat[c % 8] && (k < nnz);
      bus.ent_addr  = e.addr;
      bus.ent_w     = e.w;
      bus.ent_ia    = e.ia;
      #1;
      if (bus.ent_valid && bus.ent_ready) k++;
      @(negedge clk);
    end
    bus.ent_valid = 1'b0;
    check("done_seen", 64'(seen), 64'(exp_done));
    check("accepted", 64'(k), 64'(nnz));
    if (seen) begin
      check("groups", 64'(bus.groups), 64'(exp_groups));
      check("err_at_done", 64'(bus.err), 64'(exp_err));
      check("pe_start_count", 64'(pe_start_cnt - ps0), 64'(exp_groups));
      check("ready_after_last", 64'(late_ready), 64'(0));
      @(negedge clk);
      check("busy_after_done", 64'(bus.busy), 64'(0));
      check("done_one_cycle", 64'(bus.done), 64'(0));
    end
  endtask

  initial begin : stim
    int cd;
    int sc;
    tbl[0] = '{nnz: 3, vpat: 8'hFF,         fin: 4, exp_groups: 1};
    tbl[1] = '{nnz: 5, vpat: 8'hFF,         fin: 3, exp_groups: 2};
    tbl[2] = '{nnz: 0, vpat: 8'hFF,         fin: 4, exp_groups: 0};
    tbl[3] = '{nnz: 3, vpat: 8'b0010_1001,  fin: 2, exp_groups: 1};
    tbl[4] = '{nnz: 7, vpat: 8'b1011_0111,  fin: 2, exp_groups: 3};
    tbl[5] = '{nnz: 6, vpat: 8'hFF,         fin: 6, exp_groups: 2};
    tbl[6] = '{nnz: 1, vpat: 8'hFF,         fin: 2, exp_groups: 1};

    rst = 1'b1;
    bus.start = 1'b0; bus.nnz = '0; bus.ent_valid = 1'b0;
    bus.ent_addr = '0; bus.ent_w = '0; bus.ent_ia = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fin_dly = tbl[v].fin;
      run_tile(v, tbl[v].nnz, tbl[v].vpat, 80, 1'b1, 1'b0, tbl[v].exp_groups, cd, sc);
      if (tbl[v].nnz == 0) check("nnz0_done_latency", 64'(cd), 64'(0));
    end

    // Start during WAIT is ignored; reset during WAIT clears everything.
    pe_auto = 1'b0;
    run_tile(10, 3, 8'hFF, 6, 1'b0, 1'b0, 1, cd, sc);
    bus.start = 1'b1;
    bus.nnz   = NNZ_W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    check("wait_start_busy", 64'(bus.busy), 64'(1));
    check("wait_start_groups", 64'(bus.groups), 64'(1));
    check("wait_start_ready", 64'(bus.ent_ready), 64'(0));
    check("wait_start_lane0", 64'(bus.pe_w[0]), 64'(gen(10, 0).w));
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("wait_reset");
    rst = 1'b0;
    pe_auto = 1'b1;
    fin_dly = 4;
    run_tile(11, 3, 8'hFF, 40, 1'b1, 1'b0, 1, cd, sc);

    // PE never finishes: timeout raises err, then the next start clears it.
    pe_auto = 1'b0;
    run_tile(12, 2, 8'hFF, 400, 1'b1, 1'b1, 1, cd, sc);
    check("tmo_latency", 64'((cd - sc) >= 256 && (cd - sc) <= 257), 64'(1));
    check("err_sticky", 64'(bus.err), 64'(1));
    pe_auto = 1'b1;
    fin_dly = 3;
    run_tile(13, 4, 8'hFF, 60, 1'b1, 1'b0, 2, cd, sc);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
